// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes, mux selects and the
// control vector that travels from the output decoder to the top-level ports.
package mips_mc_pkg;

   typedef enum logic [3:0] {
      StFetch   = 4'd0,
      StDecode  = 4'd1,
      StMemAdr  = 4'd2,
      StMemRd   = 4'd3,
      StMemWb   = 4'd4,
      StMemWr   = 4'd5,
      StExecute = 4'd6,
      StAluWb   = 4'd7,
      StBranch  = 4'd8,
      StAddiEx  = 4'd9,
      StAddiWb  = 4'd10,
      StJump    = 4'd11,
      StTrap    = 4'd12
   } state_t;

   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpJ     = 6'b000010;

   localparam logic [1:0] SrcbFour  = 2'b01;
   localparam logic [1:0] SrcbImm   = 2'b10;
   localparam logic [1:0] SrcbImmSh = 2'b11;

   localparam logic [1:0] PcsrcAluOut = 2'b01;
   localparam logic [1:0] PcsrcJump   = 2'b10;

   localparam logic [1:0] AluopSub   = 2'b01;
   localparam logic [1:0] AluopFunct = 2'b10;

   typedef struct packed {
      logic       mem_req;
      logic       iord;
      logic       irwrite;
      logic       pcwrite;
      logic       branch;
      logic       memwrite;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic [1:0] aluop;
   } ctrl_t;

   // States that own the memory port and may stall on mem_ready.
   function automatic logic is_mem_wait(input state_t s);
      return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
   endfunction

endpackage

// File: rtl/mips_mc_out_decode.sv
// Control-vector decoder: pure function of the current state, with mem_ready gating the
// instruction-register and PC loads in FETCH.
module mips_mc_out_decode
   import mips_mc_pkg::*;
(
   input  state_t state,
   input  logic   mem_ready,
   output ctrl_t  ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         StFetch: begin
            ctrl.mem_req = 1'b1;
            ctrl.alusrcb = SrcbFour;
            ctrl.irwrite = mem_ready;
            ctrl.pcwrite = mem_ready;
         end
         StDecode: begin
            ctrl.alusrcb = SrcbImmSh;
         end
         StMemAdr: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SrcbImm;
         end
         StMemRd: begin
            ctrl.mem_req = 1'b1;
            ctrl.iord    = 1'b1;
         end
         StMemWb: begin
            ctrl.memtoreg = 1'b1;
            ctrl.regwrite = 1'b1;
         end
         StMemWr: begin
            ctrl.mem_req  = 1'b1;
            ctrl.iord     = 1'b1;
            ctrl.memwrite = 1'b1;
         end
         StExecute: begin
            ctrl.alusrca = 1'b1;
            ctrl.aluop   = AluopFunct;
         end
         StAluWb: begin
            ctrl.regdst   = 1'b1;
            ctrl.regwrite = 1'b1;
         end
         StBranch: begin
            ctrl.alusrca = 1'b1;
            ctrl.aluop   = AluopSub;
            ctrl.pcsrc   = PcsrcAluOut;
            ctrl.branch  = 1'b1;
         end
         StAddiEx: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SrcbImm;
         end
         StAddiWb: begin
            ctrl.regwrite = 1'b1;
         end
         StJump: begin
            ctrl.pcsrc   = PcsrcJump;
            ctrl.pcwrite = 1'b1;
         end
         // StTrap and unreachable encodings drive every control low.
         default: ;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control FSM with memory wait-state stall, sticky timeout flag and an optional
// illegal-opcode trap enabled by defining MIPS_MC_ILLEGAL_TRAP_EN.
module mips_multicycle_controller
   import mips_mc_pkg::*;
#(
   parameter int unsigned OP_W        = 6,
   parameter int unsigned ALUOP_W     = 2,
   parameter int unsigned STATE_W     = 4,
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [OP_W-1:0]    op,
   input  logic               mem_ready,
   output logic               mem_req,
   output logic               iord,
   output logic               irwrite,
   output logic               pcwrite,
   output logic               branch,
   output logic               memwrite,
   output logic               regdst,
   output logic               memtoreg,
   output logic               regwrite,
   output logic               alusrca,
   output logic [1:0]         alusrcb,
   output logic [1:0]         pcsrc,
   output logic [ALUOP_W-1:0] aluop,
   output logic [STATE_W-1:0] state_o,
   output logic               mem_timeout,
   output logic               illegal_op
);

   localparam int unsigned CntW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(MEM_TIMEOUT);

   localparam logic [OP_W-1:0] RtypeOpW = OP_W'(OpRtype);
   localparam logic [OP_W-1:0] LwOpW    = OP_W'(OpLw);
   localparam logic [OP_W-1:0] SwOpW    = OP_W'(OpSw);
   localparam logic [OP_W-1:0] BeqOpW   = OP_W'(OpBeq);
   localparam logic [OP_W-1:0] AddiOpW  = OP_W'(OpAddi);
   localparam logic [OP_W-1:0] JOpW     = OP_W'(OpJ);

   state_t          state_q, state_d;
   logic [CntW-1:0] wait_q, wait_d;
   logic            mem_timeout_q, mem_timeout_d;
   logic [3:0]      state_raw;
   ctrl_t           ctrl;

`ifdef MIPS_MC_ILLEGAL_TRAP_EN
   logic illegal_q, illegal_d;
`endif

   // Next-state logic
   always_comb begin
      state_d = state_q;
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
      illegal_d = illegal_q;
`endif
      case (state_q)
         StFetch:   if (mem_ready) state_d = StDecode;
         StDecode: begin
            case (op)
               LwOpW, SwOpW: state_d = StMemAdr;
               RtypeOpW:     state_d = StExecute;
               BeqOpW:       state_d = StBranch;
               AddiOpW:      state_d = StAddiEx;
               JOpW:         state_d = StJump;
               default: begin
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
                  state_d   = StTrap;
                  illegal_d = 1'b1;
`else
                  state_d   = StFetch;
`endif
               end
            endcase
         end
         StMemAdr:  state_d = (op == LwOpW) ? StMemRd : StMemWr;
         StMemRd:   if (mem_ready) state_d = StMemWb;
         StMemWb:   state_d = StFetch;
         StMemWr:   if (mem_ready) state_d = StFetch;
         StExecute: state_d = StAluWb;
         StAluWb:   state_d = StFetch;
         StBranch:  state_d = StFetch;
         StAddiEx:  state_d = StAddiWb;
         StAddiWb:  state_d = StFetch;
         StJump:    state_d = StFetch;
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
         StTrap:    state_d = StTrap;
`endif
         default:   state_d = StFetch;
      endcase
   end

   // A stalled memory state never changes state, so any other cycle clears the counter.
   always_comb begin
      wait_d        = '0;
      mem_timeout_d = mem_timeout_q;
      if (is_mem_wait(state_q) && !mem_ready) begin
         wait_d = (wait_q < CntMax) ? wait_q + CntW'(1) : wait_q;
      end
      if ((MEM_TIMEOUT != 0) && (wait_d == CntMax)) begin
         mem_timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= StFetch;
         wait_q        <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_q        <= wait_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

`ifdef MIPS_MC_ILLEGAL_TRAP_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         illegal_q <= 1'b0;
      end else begin
         illegal_q <= illegal_d;
      end
   end
   assign illegal_op = illegal_q;
`else
   assign illegal_op = 1'b0;
`endif

   mips_mc_out_decode u_out_decode (
      .state     (state_q),
      .mem_ready (mem_ready),
      .ctrl      (ctrl)
   );

   assign mem_req     = ctrl.mem_req;
   assign iord        = ctrl.iord;
   assign irwrite     = ctrl.irwrite;
   assign pcwrite     = ctrl.pcwrite;
   assign branch      = ctrl.branch;
   assign memwrite    = ctrl.memwrite;
   assign regdst      = ctrl.regdst;
   assign memtoreg    = ctrl.memtoreg;
   assign regwrite    = ctrl.regwrite;
   assign alusrca     = ctrl.alusrca;
   assign alusrcb     = ctrl.alusrcb;
   assign pcsrc       = ctrl.pcsrc;
   assign aluop       = ALUOP_W'(ctrl.aluop);
   assign state_raw   = state_q;
   assign state_o     = STATE_W'(state_raw);
   assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Bench for mips_multicycle_controller: directed vector table, hand-written stall/reset/trap
// sequences, then random traffic checked against a path-queue reference model.
module tb_mips_multicycle_controller;

   localparam int TO = 4;

   // Expected control vectors, bit order:
   // mem_req iord irwrite pcwrite branch memwrite regdst memtoreg regwrite alusrca
   // alusrcb[1:0] pcsrc[1:0] aluop[1:0]
   localparam logic [15:0] CFetchWait = 16'h8010;
   localparam logic [15:0] CFetchGo   = 16'hB010;
   localparam logic [15:0] CDecode    = 16'h0030;
   localparam logic [15:0] CMemAdr    = 16'h0060;
   localparam logic [15:0] CMemRd     = 16'hC000;
   localparam logic [15:0] CMemWb     = 16'h0180;
   localparam logic [15:0] CMemWr     = 16'hC400;
   localparam logic [15:0] CExecute   = 16'h0042;
   localparam logic [15:0] CAluWb     = 16'h0280;
   localparam logic [15:0] CBranch    = 16'h0845;
   localparam logic [15:0] CAddiEx    = 16'h0060;
   localparam logic [15:0] CAddiWb    = 16'h0080;
   localparam logic [15:0] CJump      = 16'h1008;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [5:0] op;
   logic       mem_ready;
   logic       mem_req, iord, irwrite, pcwrite, branch, memwrite, regdst, memtoreg, regwrite;
   logic       alusrca, mem_timeout, illegal_op;
   logic [1:0] alusrcb, pcsrc, aluop;
   logic [3:0] state_o;
   logic [15:0] act_ctrl;

   int n_tests = 0;
   int n_fail  = 0;

   mips_multicycle_controller #(
      .OP_W        (6),
      .ALUOP_W     (2),
      .STATE_W     (4),
      .MEM_TIMEOUT (TO)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .op          (op),
      .mem_ready   (mem_ready),
      .mem_req     (mem_req),
      .iord        (iord),
      .irwrite     (irwrite),
      .pcwrite     (pcwrite),
      .branch      (branch),
      .memwrite    (memwrite),
      .regdst      (regdst),
      .memtoreg    (memtoreg),
      .regwrite    (regwrite),
      .alusrca     (alusrca),
      .alusrcb     (alusrcb),
      .pcsrc       (pcsrc),
      .aluop       (aluop),
      .state_o     (state_o),
      .mem_timeout (mem_timeout),
      .illegal_op  (illegal_op)
   );

   always #5 clk = ~clk;

   assign act_ctrl = {mem_req, iord, irwrite, pcwrite, branch, memwrite, regdst, memtoreg,
                      regwrite, alusrca, alusrcb, pcsrc, aluop};

   // ---------------- reference model ----------------
   // The model holds the remaining states of the current instruction as a queue; head = now.
   int path[$];
   int mwait;
   bit mto, mill;

   function automatic void model_reset();
      path.delete();
      path.push_back(0);
      path.push_back(1);
      mwait = 0;
      mto   = 1'b0;
      mill  = 1'b0;
   endfunction

   function automatic void model_step(input logic rst, input logic rdy, input logic [5:0] opv);
      int s;
      if (!rst) begin
         model_reset();
         return;
      end
      s = path[0];
      if (s == 12) return;
      if ((s == 0 || s == 3 || s == 5) && !rdy) begin
         if (mwait < TO) mwait++;
         if (TO > 0 && mwait == TO) mto = 1'b1;
         return;
      end
      mwait = 0;
      void'(path.pop_front());
      if (s == 1) begin
         case (opv)
            6'h23: begin path.push_back(2); path.push_back(3); path.push_back(4); end
            6'h2b: begin path.push_back(2); path.push_back(5); end
            6'h00: begin path.push_back(6); path.push_back(7); end
            6'h04: path.push_back(8);
            6'h08: begin path.push_back(9); path.push_back(10); end
            6'h02: path.push_back(11);
            default: begin
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
               path.push_back(12);
               mill = 1'b1;
`endif
            end
         endcase
      end
      if (path.size() == 0) begin
         path.push_back(0);
         path.push_back(1);
      end
   endfunction

   function automatic logic [15:0] exp_ctrl(input int s, input logic rdy);
      case (s)
         0:  return rdy ? CFetchGo : CFetchWait;
         1:  return CDecode;
         2:  return CMemAdr;
         3:  return CMemRd;
         4:  return CMemWb;
         5:  return CMemWr;
         6:  return CExecute;
         7:  return CAluWb;
         8:  return CBranch;
         9:  return CAddiEx;
         10: return CAddiWb;
         11: return CJump;
         default: return 16'h0000;
      endcase
   endfunction

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic rst, input logic [5:0] opv, input logic rdy);
      @(negedge clk);
      reset_n   = rst;
      op        = opv;
      mem_ready = rdy;
      #1;
   endtask

   task automatic chk_all(input string name, input int st, input logic [15:0] c,
                          input logic to, input logic ill);
      chk({name, ".state"}, 32'(state_o), 32'(st));
      chk({name, ".ctrl"}, 32'(act_ctrl), 32'(c));
      chk({name, ".timeout"}, 32'(mem_timeout), 32'(to));
      chk({name, ".illegal"}, 32'(illegal_op), 32'(ill));
   endtask

   typedef struct {
      logic [5:0]  op;
      logic        rdy;
      int          st;
      logic [15:0] ctrl;
   } vec_t;

   vec_t vt[$];

   function automatic void add(input logic [5:0] o, input logic r, input int s,
                               input logic [15:0] c);
      vt.push_back('{o, r, s, c});
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] legal [6];
      logic [5:0] cur_op;
      logic       rdy, rst;
      int         trap_cycles;
      logic       ill_exp;

      legal[0] = 6'h00; legal[1] = 6'h23; legal[2] = 6'h2b;
      legal[3] = 6'h04; legal[4] = 6'h08; legal[5] = 6'h02;

      // R-type
      add(6'h00, 1, 0, CFetchGo); add(6'h00, 1, 1, CDecode);
      add(6'h00, 1, 6, CExecute); add(6'h00, 1, 7, CAluWb);
      // lw with three wait cycles in MEMRD: 8 cycles
      add(6'h23, 1, 0, CFetchGo); add(6'h23, 1, 1, CDecode); add(6'h23, 1, 2, CMemAdr);
      add(6'h23, 0, 3, CMemRd);   add(6'h23, 0, 3, CMemRd);  add(6'h23, 0, 3, CMemRd);
      add(6'h23, 1, 3, CMemRd);   add(6'h23, 1, 4, CMemWb);
      // sw with one wait cycle, mem_ready low in DECODE ignored
      add(6'h2b, 1, 0, CFetchGo); add(6'h2b, 0, 1, CDecode); add(6'h2b, 1, 2, CMemAdr);
      add(6'h2b, 0, 5, CMemWr);   add(6'h2b, 1, 5, CMemWr);
      // beq after a stalled fetch
      add(6'h04, 0, 0, CFetchWait); add(6'h04, 1, 0, CFetchGo);
      add(6'h04, 0, 1, CDecode);    add(6'h04, 0, 8, CBranch);
      // j
      add(6'h02, 1, 0, CFetchGo); add(6'h02, 1, 1, CDecode); add(6'h02, 1, 11, CJump);
      // addi
      add(6'h08, 1, 0, CFetchGo); add(6'h08, 1, 1, CDecode);
      add(6'h08, 0, 9, CAddiEx);  add(6'h08, 1, 10, CAddiWb);
      add(6'h00, 0, 0, CFetchWait);

      reset_n = 1'b0; op = 6'h00; mem_ready = 1'b1;
      drive(0, 6'h00, 1);
      drive(0, 6'h00, 1);
      drive(1, 6'h00, 1);
      chk_all("reset", 0, CFetchGo, 0, 0);

      for (int i = 0; i < vt.size(); i++) begin
         if (i > 0) drive(1, vt[i].op, vt[i].rdy);
         else begin op = vt[i].op; mem_ready = vt[i].rdy; #1; end
         chk_all($sformatf("vec%0d", i), vt[i].st, vt[i].ctrl, 0, 0);
      end

      // Timeout: four wait cycles in FETCH set the sticky flag.
      drive(0, 6'h00, 0);
      for (int i = 0; i < 4; i++) begin
         drive(1, 6'h00, 0);
         chk($sformatf("to_pre%0d", i), 32'(mem_timeout), 32'(0));
      end
      drive(1, 6'h00, 0);
      chk_all("to_set", 0, CFetchWait, 1, 0);
      drive(1, 6'h00, 1);
      chk_all("to_ready", 0, CFetchGo, 1, 0);
      drive(1, 6'h00, 1); chk_all("to_dec", 1, CDecode, 1, 0);
      drive(1, 6'h00, 1); chk_all("to_exe", 6, CExecute, 1, 0);
      drive(1, 6'h00, 1); chk_all("to_wb", 7, CAluWb, 1, 0);

      // Reset while stalled in MEMRD.
      drive(1, 6'h23, 1); chk("rm_fetch", 32'(state_o), 32'(0));
      drive(1, 6'h23, 1); chk("rm_dec", 32'(state_o), 32'(1));
      drive(1, 6'h23, 1); chk("rm_adr", 32'(state_o), 32'(2));
      drive(1, 6'h23, 0); chk("rm_rd0", 32'(state_o), 32'(3));
      drive(0, 6'h23, 0); chk_all("rm_rstcyc", 3, CMemRd, 1, 0);
      drive(1, 6'h23, 0); chk_all("rm_after", 0, CFetchWait, 0, 0);

      // Illegal opcode.
      drive(1, 6'h3f, 1); chk("ill_fetch", 32'(state_o), 32'(0));
      drive(1, 6'h3f, 1); chk_all("ill_dec", 1, CDecode, 0, 0);
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
      for (int k = 0; k < 4; k++) begin
         drive(1, 6'h3f, k[0]);
         chk_all($sformatf("trap%0d", k), 12, 16'h0000, 0, 1);
      end
`else
      drive(1, 6'h3f, 1); chk_all("ill_nop", 0, CFetchGo, 0, 0);
`endif
      drive(0, 6'h00, 1);
      drive(1, 6'h00, 1); chk_all("ill_reset", 0, CFetchGo, 0, 0);

      // Random traffic against the model.
      drive(0, 6'h00, 1);
      model_reset();
      cur_op = 6'h00;
      trap_cycles = 0;
      for (int n = 0; n < 2000; n++) begin
         if (path[0] == 0) begin
            if ($urandom_range(0, 15) == 15) cur_op = 6'($urandom_range(0, 63));
            else cur_op = legal[$urandom_range(0, 5)];
         end
         rdy = ($urandom_range(0, 9) < 6);
         rst = ($urandom_range(0, 199) != 0);
         if (path[0] == 12) begin
            trap_cycles++;
            if (trap_cycles > 3) rst = 1'b0;
         end else begin
            trap_cycles = 0;
         end
         drive(rst, cur_op, rdy);
         ill_exp = mill;
         chk_all($sformatf("rnd%0d", n), path[0], exp_ctrl(path[0], rdy), mto, ill_exp);
         model_step(rst, rdy, cur_op);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
